// File: rtl/numlock_gen_if.sv
`default_nettype none
// numlock_gen_if: keypad/programming inputs and lock status outputs of the combination lock.
// Revision: 1.0
interface numlock_gen_if #(
  parameter int SYM_W    = 1,
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
);
  localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int EIDX_W = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  logic              key_stb;
  logic [SYM_W-1:0]  key_sym;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_idx;
  logic [SYM_W-1:0]  prog_sym;
  logic              unlock;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;
  logic [EIDX_W-1:0] entry_idx;
  logic [4:0]        q_state;

  modport master (
    output key_stb, key_sym, prog_we, prog_idx, prog_sym,
    input  unlock, lockout, fail_cnt, entry_idx, q_state
  );

  modport slave (
    input  key_stb, key_sym, prog_we, prog_idx, prog_sym,
    output unlock, lockout, fail_cnt, entry_idx, q_state
  );
endinterface
`default_nettype wire

// File: rtl/numlock_gen.sv
`default_nettype none
// numlock_gen: programmable combination lock with entry timeout and failure lockout.
// Revision: 1.0
module numlock_gen #(
  parameter int                          SYM_W        = 1,
  parameter int                          CODE_LEN     = 4,
  parameter logic [CODE_LEN*SYM_W-1:0]   DEFAULT_CODE = 4'b1101,
  parameter int                          OPEN_CYC     = 16,
  parameter int                          LOCK_CYC     = 64,
  parameter int                          MAX_FAIL     = 3,
  parameter int                          ENTRY_TO     = 255
) (
  input  wire             clk,
  input  wire             reset,
  numlock_gen_if.slave    bus
);
  localparam int EIDX_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int TMR_MAX = (OPEN_CYC > LOCK_CYC) ?
                           ((OPEN_CYC > ENTRY_TO) ? OPEN_CYC : ENTRY_TO) :
                           ((LOCK_CYC > ENTRY_TO) ? LOCK_CYC : ENTRY_TO);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [4:0] c_IDLE  = 5'b00001;
  localparam logic [4:0] c_ENTER = 5'b00010;
  localparam logic [4:0] c_BAD   = 5'b00100;
  localparam logic [4:0] c_OPEN  = 5'b01000;
  localparam logic [4:0] c_LOCK  = 5'b10000;

  localparam logic [TMR_W-1:0]  c_OPEN_LAST = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0]  c_LOCK_LAST = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0]  c_TO_LAST   = TMR_W'((ENTRY_TO > 0) ? ENTRY_TO - 1 : 0);
  localparam logic [EIDX_W-1:0] c_LAST_IDX  = EIDX_W'(CODE_LEN - 1);

  logic [4:0]               r_state;
  logic [CODE_LEN*SYM_W-1:0] r_code;
  logic [EIDX_W-1:0]        r_eidx;
  logic [FAIL_W-1:0]        r_fail;
  logic [TMR_W-1:0]         r_tmr;

  logic [4:0]        w_state_nxt;
  logic [EIDX_W-1:0] w_eidx_nxt;
  logic [FAIL_W-1:0] w_fail_nxt;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic              w_fail_evt;
  logic [SYM_W-1:0]  w_exp_sym;
  logic              w_match;
  logic              w_last;
  logic              w_unlock;
  logic              w_lockout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_code  <= DEFAULT_CODE;
      r_eidx  <= '0;
      r_fail  <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_eidx  <= w_eidx_nxt;
      r_fail  <= w_fail_nxt;
      r_tmr   <= w_tmr_nxt;
      // Out-of-range indices match no slot and are dropped.
      if (r_state == c_IDLE && bus.prog_we) begin
        for (int i = 0; i < CODE_LEN; i++) begin
          if (bus.prog_idx == IDX_W'(i)) r_code[i*SYM_W +: SYM_W] <= bus.prog_sym;
        end
      end
    end
  end

  always_comb begin
    w_exp_sym = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (r_eidx == EIDX_W'(i)) w_exp_sym = r_code[i*SYM_W +: SYM_W];
    end
  end

  assign w_match = (bus.key_sym == w_exp_sym);
  assign w_last  = (r_eidx == c_LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_eidx_nxt  = r_eidx;
    w_fail_nxt  = r_fail;
    w_tmr_nxt   = r_tmr;
    w_fail_evt  = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_tmr_nxt = '0;
        if (bus.key_stb) begin
          if (CODE_LEN == 1) begin
            if (w_match) begin
              w_state_nxt = c_OPEN;
              w_fail_nxt  = '0;
            end else begin
              w_fail_evt = 1'b1;
            end
          end else begin
            w_state_nxt = w_match ? c_ENTER : c_BAD;
            w_eidx_nxt  = EIDX_W'(1);
          end
        end
      end
      c_ENTER, c_BAD: begin
        if (bus.key_stb) begin
          w_tmr_nxt = '0;
          if (w_last) begin
            if (w_match && r_state == c_ENTER) begin
              w_state_nxt = c_OPEN;
              w_eidx_nxt  = '0;
              w_fail_nxt  = '0;
            end else begin
              w_fail_evt = 1'b1;
            end
          end else begin
            w_eidx_nxt = r_eidx + EIDX_W'(1);
            if (!w_match) w_state_nxt = c_BAD;
          end
        end else if (ENTRY_TO > 0) begin
          // An abort is not a failure: fail count is left untouched.
          if (r_tmr == c_TO_LAST) begin
            w_state_nxt = c_IDLE;
            w_eidx_nxt  = '0;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
      end
      c_OPEN: begin
        if (r_tmr == c_OPEN_LAST) begin
          w_state_nxt = c_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      c_LOCK: begin
        if (r_tmr == c_LOCK_LAST) begin
          w_state_nxt = c_IDLE;
          w_tmr_nxt   = '0;
          w_fail_nxt  = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_eidx_nxt  = '0;
        w_fail_nxt  = '0;
        w_tmr_nxt   = '0;
      end
    endcase
    if (w_fail_evt) begin
      w_eidx_nxt = '0;
      w_tmr_nxt  = '0;
      if (int'(r_fail) + 1 >= MAX_FAIL) begin
        w_state_nxt = c_LOCK;
        w_fail_nxt  = FAIL_W'(MAX_FAIL);
      end else begin
        w_state_nxt = c_IDLE;
        w_fail_nxt  = r_fail + FAIL_W'(1);
      end
    end
  end

  always_comb begin
    w_unlock  = (r_state == c_OPEN);
    w_lockout = (r_state == c_LOCK);
  end

  assign bus.unlock    = w_unlock;
  assign bus.lockout   = w_lockout;
  assign bus.fail_cnt  = r_fail;
  assign bus.entry_idx = r_eidx;
  assign bus.q_state   = r_state;
endmodule
`default_nettype wire

// File: doc/numlock_gen.md
Name: numlock_gen

Overview:
- Parametrised combination-lock controller: generalises the fixed 4-bit, 2-button numlock to configurable symbol width, code length and timers.
- Adds a runtime-programmable code, an entry timeout and a lockout after repeated failures.
- Sits behind the debounced keypad front end, which supplies single-cycle key strobes. Drives the door actuator (unlock) and status LEDs.

Parameters:
- SYM_W, 1, bits per entered symbol.
- CODE_LEN, 4, symbols per code (>=1).
- DEFAULT_CODE, 4'b1101, reset code, CODE_LEN*SYM_W bits. Slot i = bits [i*SYM_W +: SYM_W]. Slot 0 is entered first, so the default sequence is 1,0,1,1.
- OPEN_CYC, 16, cycles unlock stays high.
- LOCK_CYC, 64, cycles spent in lockout.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1).
- ENTRY_TO, 255, idle cycles allowed mid-entry before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- key_stb  in  1  one-cycle strobe: a symbol was entered.
- key_sym  in  SYM_W  symbol value, valid when key_stb=1.
- prog_we  in  1  code-slot write enable.
- prog_idx  in  clog2(CODE_LEN) (min 1)  slot to write.
- prog_sym  in  SYM_W  value to write.
- unlock  out  1  high while in OPEN.
- lockout  out  1  high while in LOCKOUT.
- fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failed attempts.
- entry_idx  out  clog2(CODE_LEN+1)  symbols consumed in the current attempt.
- q_state  out  5  one-hot state, {LOCKOUT,OPEN,BAD,ENTER,IDLE}.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state=IDLE, code register=DEFAULT_CODE, all counters 0.
  - Outputs: unlock=0, lockout=0, fail_cnt=0, entry_idx=0, q_state=5'b00001.
  - Reset mid-operation aborts any attempt, open or lockout immediately. A programmed code reverts to DEFAULT_CODE.
- All outputs are decoded from registered state and counters. unlock rises the cycle after the final correct strobe (latency 1).
- IDLE, on key_stb:
  - Match with slot 0: if CODE_LEN=1 go to OPEN; else go to ENTER with entry_idx=1.
  - Mismatch: if CODE_LEN=1 it is a failure (see failure handling); else go to BAD with entry_idx=1.
- ENTER, on key_stb, comparing key_sym with slot[entry_idx]:
  - Match with entry_idx=CODE_LEN-1: go to OPEN.
  - Match otherwise: entry_idx+1.
  - Mismatch: go to BAD, entry_idx+1. If that was the last symbol, it is a failure instead.
- BAD: accepts strobes without comparing, so the position of the error is not revealed. entry_idx increments on each strobe. When it reaches CODE_LEN, it is a failure.
- Failure handling:
  - entry_idx clears to 0.
  - If fail_cnt+1 = MAX_FAIL: go to LOCKOUT.
  - Else: fail_cnt+1, go to IDLE.
- OPEN:
  - Held exactly OPEN_CYC cycles, then IDLE.
  - fail_cnt and entry_idx clear on entry.
  - key_stb is ignored.
- LOCKOUT:
  - Held exactly LOCK_CYC cycles, then IDLE with fail_cnt=0.
  - key_stb is ignored. fail_cnt reads MAX_FAIL while in LOCKOUT.
- Entry timeout (ENTRY_TO>0, states ENTER/BAD only):
  - The idle counter clears on each key_stb and increments otherwise.
  - When it reaches ENTRY_TO: go to IDLE, entry_idx=0, fail_cnt unchanged (an abort is not a failure).
  - key_stb in the same cycle as the timeout: the strobe wins and is processed.
- Programming:
  - prog_we is honoured only in IDLE; ignored in all other states.
  - prog_idx >= CODE_LEN is ignored.
  - A write lands at the clock edge. A key_stb in the same IDLE cycle compares against the old slot value.
- Timer widths are sized from the parameters; no counter wraps. Each counter holds at its terminal value until the state changes.
- Unused state encodings return to IDLE on the next clock.

Test Plan:
- Default parameters; after reset, strobe symbols 1,0,1,1 on consecutive cycles.
  -> unlock=1 the cycle after the 4th strobe, high exactly 16 cycles, then IDLE with unlock=0.
- Strobe 0,1,1,1 (error on the 1st symbol).
  -> q_state=BAD after the 1st strobe; stays in BAD through strobes 2-3; after the 4th, IDLE with fail_cnt=1 and unlock never high.
- Three consecutive wrong 4-symbol attempts.
  -> lockout=1 for 64 cycles, and strobing 1,0,1,1 during lockout has no effect. Then IDLE with fail_cnt=0, and a correct code opens.
- In IDLE, write prog_idx=2 with prog_sym=0, then enter 1,0,0,1.
  -> opens. The old code 1,0,1,1 now fails. prog_we issued while in ENTER does not change the code.
- Enter 1,0, then idle 255 cycles.
  -> IDLE, entry_idx=0, fail_cnt unchanged. Repeat with the strobe landing on cycle 255 -> the strobe is processed (entry_idx=3).
- Assert reset during OPEN at cycle 5.
  -> unlock=0 immediately (asynchronous). After release: IDLE, code=DEFAULT_CODE.
